// File: rtl/tl_tester_traffic_gen_if.sv
// rtl/tl_tester_traffic_gen_if.sv - tester request/response channel between traffic generator and memory side
interface tl_tester_traffic_gen_if #(
   parameter int unsigned ADDR_BITS = 32,
   parameter int unsigned DATA_BITS = 64,
   parameter int unsigned ID_BITS   = 4
);
   logic                 tlt_req_valid;
   logic                 tlt_req_ready;
   logic [ADDR_BITS-1:0] tlt_req_bits_addr;
   logic [DATA_BITS-1:0] tlt_req_bits_data;
   logic [ID_BITS-1:0]   tlt_req_bits_id;
   logic                 tlt_req_bits_is_write;
   logic                 tlt_resp_valid;
   logic [DATA_BITS-1:0] tlt_resp_bits_data;
   logic [ID_BITS-1:0]   tlt_resp_bits_id;

   modport master (
      output tlt_req_valid, tlt_req_bits_addr, tlt_req_bits_data, tlt_req_bits_id, tlt_req_bits_is_write,
      input  tlt_req_ready, tlt_resp_valid, tlt_resp_bits_data, tlt_resp_bits_id
   );

   modport slave (
      input  tlt_req_valid, tlt_req_bits_addr, tlt_req_bits_data, tlt_req_bits_id, tlt_req_bits_is_write,
      output tlt_req_ready, tlt_resp_valid, tlt_resp_bits_data, tlt_resp_bits_id
   );
endinterface

// File: rtl/tl_tester_traffic_gen.sv
// rtl/tl_tester_traffic_gen.sv - write sweep then checked read-back sweep with ID free-list and timeout
module tl_tester_traffic_gen #(
   parameter int unsigned          ADDR_BITS    = 32,
   parameter int unsigned          DATA_BITS    = 64,
   parameter int unsigned          ID_BITS      = 4,
   parameter int unsigned          MAX_INFLIGHT = 8,
   parameter int unsigned          NUM_OPS      = 256,
   parameter logic [ADDR_BITS-1:0] BASE_ADDR    = '0,
   parameter int unsigned          STRIDE       = 8,
   parameter logic [63:0]          PATTERN      = 64'hA5A5_0000_0000_0000,
   parameter int unsigned          TIMEOUT      = 1024
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   tl_tester_traffic_gen_if.master     tlt,
   output logic                        done,
   output logic                        error,
   output logic [15:0]                 err_count,
   output logic                        timeout
);
   localparam logic [2:0] S_IDLE = 3'd0, S_WRITE = 3'd1, S_DRAIN_W = 3'd2,
                          S_READ = 3'd3, S_DRAIN_R = 3'd4, S_DONE = 3'd5;
   localparam int unsigned CW = ID_BITS + 1;
   localparam logic [DATA_BITS-1:0] PAT = DATA_BITS'(PATTERN);

   function automatic logic [DATA_BITS-1:0] pat_data(input logic [15:0] i);
      return DATA_BITS'(i) ^ PAT;
   endfunction

   logic [2:0]              state;
   logic [15:0]             op_idx;
   logic [ADDR_BITS-1:0]    next_addr;
   logic                    req_valid, req_wr;
   logic [ADDR_BITS-1:0]    req_addr;
   logic [DATA_BITS-1:0]    req_data;
   logic [ID_BITS-1:0]      req_id;
   logic [15:0]             req_op;
   logic [MAX_INFLIGHT-1:0] free_q, tbl_wr;
   logic [15:0]             tbl_op [MAX_INFLIGHT];
   logic [CW-1:0]           inflight_q;
   logic [31:0]             to_cnt;

   logic                    fire, have_id, room, active, run_active, can_issue, last_fire;
   logic [MAX_INFLIGHT-1:0] fire_mask, avail, rsp_mask;
   logic [ID_BITS-1:0]      pick_id;
   logic                    rsp_v, id_ok, was_free, stray, good, mismatch, rsp_wr, to_fire;
   logic [15:0]             rsp_op;

   assign tlt.tlt_req_valid         = req_valid;
   assign tlt.tlt_req_bits_addr     = req_addr;
   assign tlt.tlt_req_bits_data     = req_data;
   assign tlt.tlt_req_bits_id       = req_id;
   assign tlt.tlt_req_bits_is_write = req_wr;

   // The allocator sees only the registered bitmap minus the ID leaving this cycle;
   // IDs freed by a response this cycle become visible one edge later.
   always_comb begin
      fire      = req_valid && tlt.tlt_req_ready;
      fire_mask = fire ? (MAX_INFLIGHT'(1) << req_id) : '0;
      avail     = free_q & ~fire_mask;
      have_id   = 1'b0;
      pick_id   = '0;
      for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
         if (avail[i]) begin
            have_id = 1'b1;
            pick_id = ID_BITS'(i);
         end
      end
      room       = (32'(inflight_q) + 32'(fire)) < MAX_INFLIGHT;
      active     = (state == S_WRITE) || (state == S_READ);
      run_active = active || (state == S_DRAIN_W) || (state == S_DRAIN_R);
      can_issue  = active && (32'(op_idx) < NUM_OPS) && have_id && room && (!req_valid || fire);
      last_fire  = fire && (32'(req_op) == NUM_OPS - 1);

      rsp_v    = tlt.tlt_resp_valid;
      id_ok    = 32'(tlt.tlt_resp_bits_id) < MAX_INFLIGHT;
      was_free = |(free_q & (MAX_INFLIGHT'(1) << tlt.tlt_resp_bits_id));
      stray    = rsp_v && (!id_ok || was_free);
      good     = rsp_v && !stray;
      rsp_op   = '0;
      rsp_wr   = 1'b0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
         if (tlt.tlt_resp_bits_id == ID_BITS'(i)) begin
            rsp_op = tbl_op[i];
            rsp_wr = tbl_wr[i];
         end
      end
      mismatch = good && !rsp_wr && (tlt.tlt_resp_bits_data != pat_data(rsp_op));
      rsp_mask = good ? (MAX_INFLIGHT'(1) << tlt.tlt_resp_bits_id) : '0;
      to_fire  = run_active && (inflight_q != '0) && !rsp_v && (to_cnt == TIMEOUT - 1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         op_idx     <= '0;
         next_addr  <= '0;
         req_valid  <= 1'b0;
         req_wr     <= 1'b0;
         req_addr   <= '0;
         req_data   <= '0;
         req_id     <= '0;
         req_op     <= '0;
         free_q     <= '1;
         tbl_wr     <= '0;
         for (int i = 0; i < MAX_INFLIGHT; i++) tbl_op[i] <= '0;
         inflight_q <= '0;
         to_cnt     <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
         err_count  <= '0;
         timeout    <= 1'b0;
      end else begin
         free_q <= (free_q & ~fire_mask) | rsp_mask;
         case ({fire, good})
            2'b10:   inflight_q <= inflight_q + CW'(1);
            2'b01:   inflight_q <= inflight_q - CW'(1);
            default: inflight_q <= inflight_q;
         endcase
         for (int i = 0; i < MAX_INFLIGHT; i++) begin
            if (fire && req_id == ID_BITS'(i)) begin
               tbl_op[i] <= req_op;
               tbl_wr[i] <= req_wr;
            end
         end

         if (can_issue) begin
            req_valid <= 1'b1;
            req_addr  <= next_addr;
            req_data  <= (state == S_WRITE) ? pat_data(op_idx) : '0;
            req_id    <= pick_id;
            req_wr    <= (state == S_WRITE);
            req_op    <= op_idx;
            op_idx    <= op_idx + 16'd1;
            next_addr <= next_addr + ADDR_BITS'(STRIDE);
         end else if (fire) begin
            req_valid <= 1'b0;
         end

         if (stray || mismatch) begin
            error <= 1'b1;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
         end
         to_cnt <= (!run_active || rsp_v || inflight_q == '0) ? '0 : to_cnt + 32'd1;

         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state      <= S_WRITE;
                  op_idx     <= '0;
                  next_addr  <= BASE_ADDR;
                  free_q     <= '1;
                  inflight_q <= '0;
                  to_cnt     <= '0;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  err_count  <= '0;
                  timeout    <= 1'b0;
               end
            end
            S_WRITE:   if (last_fire) state <= S_DRAIN_W;
            S_DRAIN_W: begin
               if (inflight_q == '0) begin
                  state     <= S_READ;
                  op_idx    <= '0;
                  next_addr <= BASE_ADDR;
               end
            end
            S_READ:    if (last_fire) state <= S_DRAIN_R;
            S_DRAIN_R: begin
               if (inflight_q == '0) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            default:   state <= S_IDLE;
         endcase

         if (to_fire) begin
            state     <= S_DONE;
            done      <= 1'b1;
            timeout   <= 1'b1;
            error     <= 1'b1;
            req_valid <= 1'b0;
         end
      end
   end
endmodule
